// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared widths and ALU opcode constants for decoder, issue stage and ALU
package operand_fetch_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_NUM    = 32;
    localparam int ADDR_WIDTH = $clog2(REG_NUM);

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

endpackage

// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - decoded-op input, writeback and ALU-side output bundle of the issue stage
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic       in_valid;
    logic       in_ready;
    addr_t      in_rs1;
    addr_t      in_rs2;
    addr_t      in_rd;
    logic [2:0] in_aluop;
    logic       in_use_imm;
    data_t      in_imm;

    logic       wb_en;
    addr_t      wb_addr;
    data_t      wb_data;

    logic       out_valid;
    logic       out_ready;
    data_t      out_A;
    data_t      out_B;
    logic [2:0] out_aluop;
    addr_t      out_rd;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_aluop, in_use_imm, in_imm,
        output wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out_A, out_B, out_aluop, out_rd
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_aluop, in_use_imm, in_imm,
        input  wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out_A, out_B, out_aluop, out_rd
    );

endinterface

// File: rtl/operand_fetch_reg_file.sv
// rtl/operand_fetch_reg_file.sv - 2 async read / 1 sync write register file, register 0 hardwired to zero
module operand_fetch_reg_file
    import operand_fetch_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_en,
    input  addr_t wr_addr,
    input  data_t wr_data,
    input  addr_t rd_addr1,
    input  addr_t rd_addr2,
    output data_t rd_data1,
    output data_t rd_data2
);

    data_t regs_q [REG_NUM];
    data_t regs_d [REG_NUM];

    always_comb begin
        regs_d = regs_q;
        if (wr_en && wr_addr != '0) begin
            regs_d[wr_addr] = wr_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_data1 = regs_q[rd_addr1];
    assign rd_data2 = regs_q[rd_addr2];

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - issue stage: register read, pending-write scoreboard, ALU operand register
// Optional same-cycle writeback forwarding is compiled in with OPFETCH_BYPASS_EN.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input logic          clk,
    input logic          rst,
    operand_fetch_if.slave bus
);

    logic [REG_NUM-1:0] busy_q, busy_d;
    logic               out_valid_q, out_valid_d;
    data_t              out_a_q, out_a_d;
    data_t              out_b_q, out_b_d;
    logic [2:0]         out_aluop_q, out_aluop_d;
    addr_t              out_rd_q, out_rd_d;

    data_t rf_rs1, rf_rs2, src1, src2;
    logic  fwd_rs1, fwd_rs2, pend_rs1, pend_rs2, waw, hazard, in_ready, accept;

    operand_fetch_reg_file u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (bus.wb_en),
        .wr_addr  (bus.wb_addr),
        .wr_data  (bus.wb_data),
        .rd_addr1 (bus.in_rs1),
        .rd_addr2 (bus.in_rs2),
        .rd_data1 (rf_rs1),
        .rd_data2 (rf_rs2)
    );

`ifdef OPFETCH_BYPASS_EN
    assign fwd_rs1 = bus.wb_en && bus.wb_addr == bus.in_rs1 && bus.in_rs1 != '0;
    assign fwd_rs2 = bus.wb_en && bus.wb_addr == bus.in_rs2 && bus.in_rs2 != '0;
`else
    assign fwd_rs1 = 1'b0;
    assign fwd_rs2 = 1'b0;
`endif

    assign src1     = fwd_rs1 ? bus.wb_data : rf_rs1;
    assign src2     = fwd_rs2 ? bus.wb_data : rf_rs2;
    assign pend_rs1 = bus.in_rs1 != '0 && busy_q[bus.in_rs1] && !fwd_rs1;
    assign pend_rs2 = bus.in_rs2 != '0 && busy_q[bus.in_rs2] && !fwd_rs2;
    // A retiring writer frees its destination for a new writer even without forwarding.
    assign waw      = bus.in_rd != '0 && busy_q[bus.in_rd]
                      && !(bus.wb_en && bus.wb_addr == bus.in_rd);
    assign hazard   = pend_rs1 || (!bus.in_use_imm && pend_rs2) || waw;
    assign in_ready = !rst && !hazard && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_aluop_d = out_aluop_q;
        out_rd_d    = out_rd_q;

        if (bus.wb_en) begin
            busy_d[bus.wb_addr] = 1'b0;
        end
        if (accept && bus.in_rd != '0) begin
            busy_d[bus.in_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (accept) begin
            out_valid_d = 1'b1;
            out_a_d     = src1;
            out_b_d     = bus.in_use_imm ? bus.in_imm : src2;
            out_aluop_d = bus.in_aluop;
            out_rd_d    = bus.in_rd;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_aluop_q <= '0;
            out_rd_q    <= '0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_aluop_q <= out_aluop_d;
            out_rd_q    <= out_rd_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_A     = out_a_q;
    assign bus.out_B     = out_b_q;
    assign bus.out_aluop = out_aluop_q;
    assign bus.out_rd    = out_rd_q;

endmodule
